// File: rtl/axis_header_insert_arbiter.sv
// Round-robin arbiter that hands one header at a time to a shared header-insert datapath.
// Latency: req_ready (combinational, IDLE) -> valid_insert 1 cycle; grant held until datapath EOP.
// Backpressure: header held on valid_insert until ready_insert; no new grant until mon last-beat handshake.
module axis_header_insert_arbiter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int NUM_REQ      = 4,
    parameter int REQ_IDX_WD   = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WD-1:0]      req_data,
    input  logic [NUM_REQ*DATA_BYTE_WD-1:0] req_keep,
    input  logic [NUM_REQ*BYTE_CNT_WD-1:0]  req_byte_cnt,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            valid_insert,
    output logic [DATA_WD-1:0]              data_insert,
    output logic [DATA_BYTE_WD-1:0]         keep_insert,
    output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
    input  logic                            ready_insert,
    input  logic                            mon_valid,
    input  logic                            mon_ready,
    input  logic                            mon_last,
    output logic [REQ_IDX_WD-1:0]           grant_idx,
    output logic                            busy,
    output logic [15:0]                     pkt_cnt,
    output logic                            err_hdr,
    output logic                            err_eop,
    input  logic                            err_clr
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_EOP = 2'd2
    } state_t;

    state_t                   r_state;
    logic [REQ_IDX_WD-1:0]    r_rr_ptr;
    logic [REQ_IDX_WD-1:0]    r_grant_idx;
    logic                     r_valid_insert;
    logic [DATA_WD-1:0]       r_data;
    logic [DATA_BYTE_WD-1:0]  r_keep;
    logic [BYTE_CNT_WD-1:0]   r_cnt;
    logic [15:0]              r_pkt_cnt;
    logic                     r_err_hdr;
    logic                     r_err_eop;

    logic [DATA_WD-1:0]       w_req_data [NUM_REQ];
    logic [DATA_BYTE_WD-1:0]  w_req_keep [NUM_REQ];
    logic [BYTE_CNT_WD-1:0]   w_req_cnt  [NUM_REQ];

    logic                     w_any;
    logic [REQ_IDX_WD-1:0]    w_gnt_idx;
    logic [REQ_IDX_WD:0]      w_sum;
    logic [REQ_IDX_WD-1:0]    w_idx;
    logic [NUM_REQ-1:0]       w_req_ready;
    logic                     w_capture;
    logic [REQ_IDX_WD-1:0]    w_next_ptr;
    logic [DATA_BYTE_WD-1:0]  w_sel_keep;
    logic [BYTE_CNT_WD-1:0]   w_sel_cnt;
    logic                     w_keep_contig;
    logic                     w_hdr_bad;
    logic                     w_eop;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_req_data[i] = req_data[i*DATA_WD +: DATA_WD];
            w_req_keep[i] = req_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
            w_req_cnt[i]  = req_byte_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
        end
    end

    // First valid requester at or above the rr pointer, wrapping past NUM_REQ-1.
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        w_idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (REQ_IDX_WD+1)'(i);
            if (w_sum >= (REQ_IDX_WD+1)'(NUM_REQ)) begin
                w_sum = w_sum - (REQ_IDX_WD+1)'(NUM_REQ);
            end
            w_idx = w_sum[REQ_IDX_WD-1:0];
            if (!w_any && req_valid[w_idx]) begin
                w_any     = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
    end

    assign w_capture  = (r_state == IDLE) && w_any;
    assign w_next_ptr = (w_gnt_idx == REQ_IDX_WD'(NUM_REQ-1)) ? '0 : w_gnt_idx + REQ_IDX_WD'(1);

    always_comb begin
        w_req_ready = '0;
        if (w_capture) begin
            w_req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // A well-formed keep is a run of ones from the LSB whose length equals the byte count.
    assign w_sel_keep    = w_req_keep[w_gnt_idx];
    assign w_sel_cnt     = w_req_cnt[w_gnt_idx];
    assign w_keep_contig = ((w_sel_keep & (w_sel_keep + DATA_BYTE_WD'(1))) == '0);
    assign w_hdr_bad     = !w_keep_contig || ($countones(w_sel_keep) != int'(w_sel_cnt));
    assign w_eop         = mon_valid && mon_ready && mon_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_rr_ptr       <= '0;
            r_grant_idx    <= '0;
            r_valid_insert <= 1'b0;
            r_data         <= '0;
            r_keep         <= '0;
            r_cnt          <= '0;
            r_pkt_cnt      <= '0;
            r_err_hdr      <= 1'b0;
            r_err_eop      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_data         <= w_req_data[w_gnt_idx];
                        r_keep         <= w_sel_keep;
                        r_cnt          <= w_sel_cnt;
                        r_grant_idx    <= w_gnt_idx;
                        r_rr_ptr       <= w_next_ptr;
                        r_valid_insert <= 1'b1;
                        r_state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ready_insert) begin
                        r_valid_insert <= 1'b0;
                        r_state        <= WAIT_EOP;
                    end
                end
                WAIT_EOP: begin
                    if (w_eop) begin
                        r_pkt_cnt <= r_pkt_cnt + 16'd1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_capture && w_hdr_bad) begin
                r_err_hdr <= 1'b1;
            end else if (err_clr) begin
                r_err_hdr <= 1'b0;
            end

            // Any EOP outside WAIT_EOP is stray, including one coinciding with the header handshake.
            if (w_eop && (r_state != WAIT_EOP)) begin
                r_err_eop <= 1'b1;
            end else if (err_clr) begin
                r_err_eop <= 1'b0;
            end
        end
    end

    assign req_ready       = w_req_ready;
    assign valid_insert    = r_valid_insert;
    assign data_insert     = r_data;
    assign keep_insert     = r_keep;
    assign byte_insert_cnt = r_cnt;
    assign grant_idx       = r_grant_idx;
    assign busy            = (r_state != IDLE);
    assign pkt_cnt         = r_pkt_cnt;
    assign err_hdr         = r_err_hdr;
    assign err_eop         = r_err_eop;

endmodule
